// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU writeback stage: condition codes, flag
// bit positions, the queued entry layout and the condition evaluator.
package alu_writeback_pkg;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_MI = 3'b011;
  localparam logic [2:0] COND_PL = 3'b100;
  localparam logic [2:0] COND_CS = 3'b101;
  localparam logic [2:0] COND_VS = 3'b110;
  localparam logic [2:0] COND_NV = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef struct packed {
    logic [7:0] result;
    logic [3:0] nzvc;
    logic [1:0] rd;
    logic       we;
    logic       fe;
    logic [2:0] cond;
  } wb_entry_t;

  // Evaluate a commit condition against the currently stored flags.
  function automatic logic cond_pass(input logic [2:0] cond, input logic [3:0] fl);
    logic p;
    case (cond)
      COND_AL: p = 1'b1;
      COND_EQ: p = fl[FLAG_Z];
      COND_NE: p = !fl[FLAG_Z];
      COND_MI: p = fl[FLAG_N];
      COND_PL: p = !fl[FLAG_N];
      COND_CS: p = fl[FLAG_C];
      COND_VS: p = fl[FLAG_V];
      default: p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/alu_writeback_fifo.sv
// Small synchronous FIFO holding pending writeback entries. Head data is
// presented combinationally so the commit logic can look ahead.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign rdata  = r_mem[r_rptr];

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Entry storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage: queues ALU results, commits one per cycle into a 4x8
// register file and NZVC flag register under a flag-based condition, and
// serves the ALU operand read ports with a bypass from the committing head.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_result,
  input  logic [3:0]       in_nzvc,
  input  logic [1:0]       in_rd,
  input  logic             in_we,
  input  logic             in_fe,
  input  logic [2:0]       in_cond,
  input  logic             wb_stall,
  input  logic [1:0]       rs_a,
  input  logic [1:0]       rs_b,
  output logic [7:0]       rdata_a,
  output logic [7:0]       rdata_b,
  output logic [3:0]       flags,
  output logic             wb_valid,
  output logic             wb_taken,
  output logic             busy,
  output logic [CNT_W-1:0] commit_cnt,
  output logic [CNT_W-1:0] skip_cnt
);
  localparam int EW = $bits(wb_entry_t);

  wb_entry_t        w_in;
  wb_entry_t        w_head;
  logic [EW-1:0]    w_head_bits;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_pass;
  logic             w_wr;

  logic [3:0][7:0]  r_regs;
  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_commit_cnt;
  logic [CNT_W-1:0] r_skip_cnt;
  logic             r_wb_valid;
  logic             r_wb_taken;

  assign w_in   = '{result: in_result, nzvc: in_nzvc, rd: in_rd,
                    we: in_we, fe: in_fe, cond: in_cond};
  assign w_head = wb_entry_t'(w_head_bits);

  // Readiness ignores a same-cycle pop so a full FIFO never takes a push.
  assign in_ready = !w_full && !rst;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = !w_empty && !wb_stall && !rst;
  assign w_pass   = cond_pass(w_head.cond, r_flags);
  assign w_wr     = w_pop && w_pass && w_head.we;

  wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_in),
    .rdata (w_head_bits),
    .full  (w_full),
    .empty (w_empty)
  );

  // Commit the head entry: register/flag update on pass, counters either way.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs       <= '0;
      r_flags      <= '0;
      r_commit_cnt <= '0;
      r_skip_cnt   <= '0;
    end else if (w_pop) begin
      if (w_pass) begin
        if (w_head.we) r_regs[w_head.rd] <= w_head.result;
        if (w_head.fe) r_flags           <= w_head.nzvc;
        r_commit_cnt <= r_commit_cnt + CNT_W'(1);
      end else begin
        r_skip_cnt <= r_skip_cnt + CNT_W'(1);
      end
    end
  end

  // One-cycle status pulse describing the pop on the previous edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_taken <= 1'b0;
    end else begin
      r_wb_valid <= w_pop;
      r_wb_taken <= w_pop && w_pass;
    end
  end

  // Operand reads forward the head result when it writes that register now.
  always_comb begin
    rdata_a = r_regs[rs_a];
    rdata_b = r_regs[rs_b];
    if (w_wr && (w_head.rd == rs_a)) rdata_a = w_head.result;
    if (w_wr && (w_head.rd == rs_b)) rdata_b = w_head.result;
  end

  assign flags      = r_flags;
  assign wb_valid   = r_wb_valid;
  assign wb_taken   = r_wb_taken;
  assign busy       = !w_empty;
  assign commit_cnt = r_commit_cnt;
  assign skip_cnt   = r_skip_cnt;

endmodule

// File: tb/tb_alu_writeback.sv
// Randomized and directed bench for alu_writeback against a queue-based model.
module tb_alu_writeback;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_result;
  logic [3:0]       in_nzvc;
  logic [1:0]       in_rd;
  logic             in_we;
  logic             in_fe;
  logic [2:0]       in_cond;
  logic             wb_stall;
  logic [1:0]       rs_a;
  logic [1:0]       rs_b;
  logic [7:0]       rdata_a;
  logic [7:0]       rdata_b;
  logic [3:0]       flags;
  logic             wb_valid;
  logic             wb_taken;
  logic             busy;
  logic [CNT_W-1:0] commit_cnt;
  logic [CNT_W-1:0] skip_cnt;

  alu_writeback #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_nzvc(in_nzvc), .in_rd(in_rd), .in_we(in_we),
    .in_fe(in_fe), .in_cond(in_cond), .wb_stall(wb_stall), .rs_a(rs_a),
    .rs_b(rs_b), .rdata_a(rdata_a), .rdata_b(rdata_b), .flags(flags),
    .wb_valid(wb_valid), .wb_taken(wb_taken), .busy(busy),
    .commit_cnt(commit_cnt), .skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic [3:0] nzvc;
    logic [1:0] rd;
    logic       we;
    logic       fe;
    logic [2:0] cond;
  } ent_t;

  ent_t       m_q[$];
  logic [7:0] m_regs [4];
  logic [3:0] m_flags;
  logic [7:0] m_cc;
  logic [7:0] m_sc;
  logic       m_vld;
  logic       m_tkn;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Condition table written directly from named flags.
  function automatic logic m_ok(input logic [2:0] c, input logic [3:0] f);
    logic n, z, v, cy;
    {n, z, v, cy} = f;
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return n;
      3'd4: return !n;
      3'd5: return cy;
      3'd6: return v;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] m_read(input logic [1:0] a);
    if (!rst && !wb_stall && m_q.size() > 0 && m_ok(m_q[0].cond, m_flags)
        && m_q[0].we && m_q[0].rd == a)
      return m_q[0].res;
    return m_regs[a];
  endfunction

  task automatic check_all();
    chk("in_ready", 8'(in_ready), 8'(!rst && m_q.size() < DEPTH));
    chk("busy", 8'(busy), 8'(m_q.size() != 0));
    chk("rdata_a", rdata_a, m_read(rs_a));
    chk("rdata_b", rdata_b, m_read(rs_b));
    chk("flags", 8'(flags), 8'(m_flags));
    chk("wb_valid", 8'(wb_valid), 8'(m_vld));
    chk("wb_taken", 8'(wb_taken), 8'(m_tkn));
    chk("commit_cnt", commit_cnt, m_cc);
    chk("skip_cnt", skip_cnt, m_sc);
  endtask

  task automatic model_step();
    ent_t e;
    bit   do_push;
    if (rst) begin
      m_q.delete();
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      m_flags = 4'h0; m_cc = 8'h00; m_sc = 8'h00; m_vld = 1'b0; m_tkn = 1'b0;
      return;
    end
    do_push = in_valid && (m_q.size() < DEPTH);
    if (m_q.size() > 0 && !wb_stall) begin
      e = m_q.pop_front();
      m_vld = 1'b1;
      m_tkn = m_ok(e.cond, m_flags);
      if (m_tkn) begin
        if (e.we) m_regs[e.rd] = e.res;
        if (e.fe) m_flags = e.nzvc;
        m_cc = m_cc + 8'd1;
      end else begin
        m_sc = m_sc + 8'd1;
      end
    end else begin
      m_vld = 1'b0; m_tkn = 1'b0;
    end
    if (do_push) begin
      e.res = in_result; e.nzvc = in_nzvc; e.rd = in_rd;
      e.we = in_we; e.fe = in_fe; e.cond = in_cond;
      m_q.push_back(e);
    end
  endtask

  // One clock: check outputs at the falling edge, advance model, then edge.
  task automatic cyc();
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [7:0] r, input logic [3:0] nz,
                     input logic [1:0] rd, input logic we, input logic fe,
                     input logic [2:0] c, input logic st);
    in_valid = v; in_result = r; in_nzvc = nz; in_rd = rd;
    in_we = we; in_fe = fe; in_cond = c; wb_stall = st;
  endtask

  task automatic idle();
    drv(1'b0, 8'h00, 4'h0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); cyc(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rs_a = 2'd0; rs_b = 2'd0; idle();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_flags = 4'h0; m_cc = 8'h00; m_sc = 8'h00; m_vld = 1'b0; m_tkn = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Basic always-commit with register and flag write.
    rs_a = 2'd2; rs_b = 2'd0;
    drv(1'b1, 8'h5A, 4'h0, 2'd2, 1'b1, 1'b1, 3'd0, 1'b0); cyc();
    idle(); cyc();
    chk("tp1_valid", 8'(wb_valid), 8'h01);
    chk("tp1_taken", 8'(wb_taken), 8'h01);
    chk("tp1_r2", rdata_a, 8'h5A);
    chk("tp1_cc", commit_cnt, 8'h01);

    // Flag-conditional commits with Z set.
    rs_a = 2'd1; rs_b = 2'd3;
    drv(1'b1, 8'h00, 4'b0100, 2'd0, 1'b0, 1'b1, 3'd0, 1'b0); cyc();
    drv(1'b1, 8'h11, 4'h0, 2'd1, 1'b1, 1'b0, 3'd1, 1'b0); cyc();
    drv(1'b1, 8'h22, 4'h0, 2'd3, 1'b1, 1'b0, 3'd2, 1'b0); cyc();
    idle(); cyc(); cyc();
    chk("tp2_r1", rdata_a, 8'h11);
    chk("tp2_r3", rdata_b, 8'h00);
    chk("tp2_sc", skip_cnt, 8'h01);
    chk("tp2_cc", commit_cnt, 8'h03);

    // Stall fills the FIFO; third push refused.
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 8'h30 + 8'(i), 4'h0, 2'(i), 1'b1, 1'b0, 3'd0, 1'b1); cyc();
    end
    chk("tp3_full", 8'(in_ready), 8'h00);
    idle(); cyc();
    chk("tp3_drain1", 8'(in_ready), 8'h01);
    cyc(); cyc();

    // Bypass of head result to both read ports, fe=0 keeps flags.
    rs_a = 2'd1; rs_b = 2'd1;
    drv(1'b1, 8'hA5, 4'hF, 2'd1, 1'b1, 1'b0, 3'd0, 1'b1); cyc();
    idle(); #1;
    chk("tp4_byp_a", rdata_a, 8'hA5);
    chk("tp4_byp_b", rdata_b, 8'hA5);
    cyc(); cyc();

    // Reset while full under stall discards the queue.
    drv(1'b1, 8'h77, 4'hF, 2'd0, 1'b1, 1'b1, 3'd0, 1'b1); cyc(); cyc();
    rst = 1'b1; cyc(); rst = 1'b0; idle(); #1;
    chk("tp5_busy", 8'(busy), 8'h00);
    chk("tp5_ready", 8'(in_ready), 8'h01);
    chk("tp5_flags", 8'(flags), 8'h00);
    chk("tp5_valid", 8'(wb_valid), 8'h00);
    cyc(); cyc();

    // Counter wrap after 256 commits, then a never-condition skip.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      drv(1'b1, 8'(i), 4'h0, 2'(i), 1'b0, 1'b0, 3'd0, 1'b0); cyc();
    end
    idle(); cyc();
    chk("tp6_wrap", commit_cnt, 8'h00);
    drv(1'b1, 8'hEE, 4'hF, 2'd0, 1'b1, 1'b1, 3'd7, 1'b0); cyc();
    idle(); cyc();
    chk("tp6_skip", skip_cnt, 8'h01);
    rs_a = 2'd0; #1;
    chk("tp6_r0", rdata_a, 8'h00);

    // Random traffic with varying stall pressure and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_result = 8'($urandom);
      in_nzvc   = 4'($urandom);
      in_rd     = 2'($urandom);
      in_we     = ($urandom_range(0, 3) != 0);
      in_fe     = $urandom_range(0, 1) == 1;
      in_cond   = 3'($urandom);
      wb_stall  = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 20 : 70));
      rs_a      = 2'($urandom);
      rs_b      = 2'($urandom);
      cyc();
    end
    rst = 1'b0; idle(); cyc(); cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
